// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, feeds instr_mem and fills IF/ID.
// Handles stall, redirect/flush and a sticky HALTED state.
module fetch_unit #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [3:0]  HALT_OPCODE = 4'hF,
  parameter logic [15:0] NOP_INSTR   = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic [15:0] instr_in,
  output logic [15:0] pc_out,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc,
  output logic        if_id_valid,
  output logic        halted,
  output logic [15:0] fetch_count
);

  typedef enum logic {
    S_RUN,
    S_HALTED
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] ifpc_q, ifpc_d;
  logic        valid_q, valid_d;
  logic [15:0] cnt_q, cnt_d;

  logic [15:0] tgt;
  logic [15:0] cnt_inc;
  logic        is_halt;

  assign tgt     = {redirect_pc[15:1], 1'b0};
  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  assign is_halt = (instr_in[15:12] == HALT_OPCODE);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_RUN: begin
        if (redirect) begin
          pc_d    = tgt;
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
        end else if (!stall) begin
          instr_d = instr_in;
          ifpc_d  = pc_q;
          valid_d = 1'b1;
          cnt_d   = cnt_inc;
          // A halt is delivered once; the PC parks on it.
          if (is_halt) begin
            state_d = S_HALTED;
          end else begin
            pc_d = pc_q + 16'd2;
          end
        end
      end
      S_HALTED: begin
        if (redirect) begin
          pc_d    = tgt;
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          state_d = S_RUN;
        end else if (!stall) begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      ifpc_q  <= 16'h0000;
      valid_q <= 1'b0;
      cnt_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc_out      = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc    = ifpc_q;
  assign if_id_valid = valid_q;
  assign halted      = (state_q == S_HALTED);
  assign fetch_count = cnt_q;

endmodule
